// File: rtl/sigdecode_z_seq.sv
// sigdecode_z_seq: streams packed (GAMMA1+1)-bit z words from signature memory,
// maps each back to a coefficient mod q and writes them to coefficient memory.
// Two read ports (even/odd addresses) feed two write ports, four lanes each.
// Optional z norm check is compiled in with SIGDECODE_Z_NORM_CHK_EN.

package sigdecode_z_pkg;
  localparam int ABR_MEM_ADDR_WIDTH = 15;
  localparam int MLDSA_N            = 256;
  localparam int MLDSA_Q            = 8380417;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;

  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } sig_mem_if_t;
endpackage

// Per-lane combinational decode of one packed z word.
module sigdecode_z_lane
  import sigdecode_z_pkg::*;
#(
  parameter int REG_SIZE = 24,
  parameter int GAMMA1   = 19
`ifdef SIGDECODE_Z_NORM_CHK_EN
  , parameter int BETA   = 120
`endif
) (
  input  logic [GAMMA1:0]     v_i,
  output logic [REG_SIZE-1:0] coef_o
`ifdef SIGDECODE_Z_NORM_CHK_EN
  , output logic              viol_o
`endif
);
  localparam logic [GAMMA1:0]     G_V = {1'b1, {GAMMA1{1'b0}}};
  localparam logic [REG_SIZE-1:0] G_X = REG_SIZE'(G_V);
  localparam logic [REG_SIZE-1:0] Q_X = REG_SIZE'(MLDSA_Q);

  logic [REG_SIZE-1:0] v_x;
  assign v_x = REG_SIZE'(v_i);

  // z = G - v; v above G means z is negative, so lift it by q into [0, q)
  assign coef_o = (v_i <= G_V) ? (G_X - v_x) : (Q_X + G_X - v_x);

`ifdef SIGDECODE_Z_NORM_CHK_EN
  // |z| >= G - BETA  <=>  v <= BETA  or  v >= 2G - BETA (2G wraps to 0 here)
  localparam logic [GAMMA1:0] LO_V = (GAMMA1+1)'(BETA);
  localparam logic [GAMMA1:0] HI_V = G_V + G_V - LO_V;
  assign viol_o = (v_i <= LO_V) || (v_i >= HI_V);
`endif
endmodule

module sigdecode_z_seq
  import sigdecode_z_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ABR_MEM_ADDR_WIDTH,
  parameter int REG_SIZE       = 24,
  parameter int GAMMA1         = 19,
  parameter int NUM_POLY       = 7,
  parameter int BETA           = 120
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           zeroize,
  input  logic                           sigdecode_z_enable,
  input  logic [MEM_ADDR_WIDTH-1:0]      src_base_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]      dest_base_addr,
  output sig_mem_if_t                    sigmem_a_rd_req,
  output sig_mem_if_t                    sigmem_b_rd_req,
  input  logic [3:0][GAMMA1:0]           sigmem_a_rd_data,
  input  logic [3:0][GAMMA1:0]           sigmem_b_rd_data,
  output mem_if_t                        mem_a_wr_req,
  output mem_if_t                        mem_b_wr_req,
  output logic [3:0][REG_SIZE-1:0]       mem_a_wr_data,
  output logic [3:0][REG_SIZE-1:0]       mem_b_wr_data,
  output logic                           sigdecode_z_done
`ifdef SIGDECODE_Z_NORM_CHK_EN
  , output logic                         z_norm_fail
`endif
);
  localparam int NUM_LANES = 8;
  localparam int NUM_WORDS = NUM_POLY * MLDSA_N / 4;
  localparam int NUM_PAIRS = NUM_WORDS / 2;
  localparam int CNT_W     = $clog2(NUM_PAIRS);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_WR, DRAIN1, DRAIN2, DONE} state_e;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0]          src_q, src_d, dest_q, dest_d;
  logic [1:0]                         vld_pipe_q, vld_pipe_d;
  sig_mem_if_t                        rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  mem_if_t                            wr_a_q, wr_a_d, wr_b_q, wr_b_d;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] wr_data_q, wr_data_d;
  logic                               done_q, done_d;
  logic                               start, rd_issue;
  logic [MEM_ADDR_WIDTH-1:0]          rd_addr, wr_addr;

  logic [NUM_LANES-1:0][GAMMA1:0]     lane_v;
  logic [NUM_LANES-1:0][REG_SIZE-1:0] lane_coef;
`ifdef SIGDECODE_Z_NORM_CHK_EN
  logic [NUM_LANES-1:0]               lane_viol, viol_q;
  logic                               fail_q;
`endif

  // lanes 0..3 come from port a, 4..7 from port b
  assign lane_v = {sigmem_b_rd_data, sigmem_a_rd_data};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sigdecode_z_lane #(
      .REG_SIZE(REG_SIZE),
      .GAMMA1  (GAMMA1)
`ifdef SIGDECODE_Z_NORM_CHK_EN
      , .BETA  (BETA)
`endif
    ) u_lane (
      .v_i   (lane_v[i]),
      .coef_o(lane_coef[i])
`ifdef SIGDECODE_Z_NORM_CHK_EN
      , .viol_o(lane_viol[i])
`endif
    );
  end

  // Next-state, read issue and the write stage two cycles behind the reads
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    src_d    = src_q;
    dest_d   = dest_q;
    start    = 1'b0;
    rd_issue = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (sigdecode_z_enable) begin
        start    = 1'b1;
        src_d    = src_base_addr;
        dest_d   = dest_base_addr;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        state_d  = RD;
      end
      RD: begin
        rd_issue = 1'b1;
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        state_d  = RD_WR;
      end
      RD_WR: begin
        rd_issue = 1'b1;
        if (rd_cnt_q == LAST_PAIR) state_d = DRAIN1;
        else                       rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
      DRAIN1:  state_d = DRAIN2;
      DRAIN2:  state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_addr = src_q + MEM_ADDR_WIDTH'({rd_cnt_q, 1'b0});
    rd_a_d  = '0;
    rd_b_d  = '0;
    if (rd_issue) begin
      rd_a_d.rd_wr_en = RW_READ;
      rd_a_d.addr     = ABR_MEM_ADDR_WIDTH'(rd_addr);
      rd_b_d.rd_wr_en = RW_READ;
      rd_b_d.addr     = ABR_MEM_ADDR_WIDTH'(rd_addr + MEM_ADDR_WIDTH'(1));
    end
    vld_pipe_d = {vld_pipe_q[0], rd_issue};

    // vld_pipe_q[1] marks the cycle the read data for a pair is on the bus
    wr_addr   = dest_q + MEM_ADDR_WIDTH'({wr_cnt_q, 1'b0});
    wr_a_d    = '0;
    wr_b_d    = '0;
    wr_data_d = '0;
    if (vld_pipe_q[1]) begin
      wr_a_d.rd_wr_en = RW_WRITE;
      wr_a_d.addr     = ABR_MEM_ADDR_WIDTH'(wr_addr);
      wr_b_d.rd_wr_en = RW_WRITE;
      wr_b_d.addr     = ABR_MEM_ADDR_WIDTH'(wr_addr + MEM_ADDR_WIDTH'(1));
      wr_data_d       = lane_coef;
      wr_cnt_d        = wr_cnt_q + CNT_W'(1);
    end
  end

  // State and pipeline registers; zeroize wipes everything like reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      vld_pipe_q <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      wr_a_q     <= '0;
      wr_b_q     <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else if (zeroize) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      vld_pipe_q <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      wr_a_q     <= '0;
      wr_b_q     <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      vld_pipe_q <= vld_pipe_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      wr_a_q     <= wr_a_d;
      wr_b_q     <= wr_b_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign sigmem_a_rd_req  = rd_a_q;
  assign sigmem_b_rd_req  = rd_b_q;
  assign mem_a_wr_req     = wr_a_q;
  assign mem_b_wr_req     = wr_b_q;
  assign mem_a_wr_data    = wr_data_q[3:0];
  assign mem_b_wr_data    = wr_data_q[7:4];
  assign sigdecode_z_done = done_q;

`ifdef SIGDECODE_Z_NORM_CHK_EN
  // viol_q lines up with the visible write; the sticky flag lands a cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_q <= '0;
      fail_q <= 1'b0;
    end else if (zeroize) begin
      viol_q <= '0;
      fail_q <= 1'b0;
    end else begin
      viol_q <= vld_pipe_q[1] ? lane_viol : '0;
      fail_q <= start ? 1'b0 : (fail_q | (|viol_q));
    end
  end

  assign z_norm_fail = fail_q;
`endif
endmodule

// File: tb/tb_sigdecode_z_seq.sv
// Directed bench for sigdecode_z_seq with a run-level reference model:
// each accepted enable defines where every read, write and done must appear.
module tb_sigdecode_z_seq;
  import sigdecode_z_pkg::*;

  localparam int P    = 224;
  localparam int G    = 524288;
  localparam int Q    = 8380417;
  localparam int BETA = 120;

  logic clk = 1'b0, reset_n = 1'b0, zeroize = 1'b0, en = 1'b0;
  logic [14:0] src = '0, dst = '0;
  sig_mem_if_t rd_a, rd_b;
  logic [3:0][19:0] rdd_a = '0, rdd_b = '0;
  mem_if_t wr_a, wr_b;
  logic [3:0][23:0] wd_a, wd_b;
  logic done;
`ifdef SIGDECODE_Z_NORM_CHK_EN
  logic nfail;
  logic m_flag;
`endif

  int tests = 0, fails = 0;
  int nreads = 0, ndone = 0;
  logic [14:0] last_rd_b, last_wr_b;
  logic [3:0][19:0] smem [0:32767];

  // reference model state
  int cyc = 0, m_e = 0;
  logic m_act = 1'b0;
  logic [14:0] m_src, m_dst;

  sigdecode_z_seq dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .sigdecode_z_enable(en),
    .src_base_addr(src), .dest_base_addr(dst),
    .sigmem_a_rd_req(rd_a), .sigmem_b_rd_req(rd_b),
    .sigmem_a_rd_data(rdd_a), .sigmem_b_rd_data(rdd_b),
    .mem_a_wr_req(wr_a), .mem_b_wr_req(wr_b),
    .mem_a_wr_data(wd_a), .mem_b_wr_data(wd_b),
    .sigdecode_z_done(done)
`ifdef SIGDECODE_Z_NORM_CHK_EN
    , .z_norm_fail(nfail)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] dec_ref(input logic [19:0] v);
    int z;
    z = G - int'(v);
    if (z < 0) z = z + Q;
    return 24'(z);
  endfunction

  function automatic logic norm_ref(input logic [19:0] v);
    int z;
    z = G - int'(v);
    if (z < 0) z = -z;
    return z >= G - BETA;
  endfunction

  function automatic logic [14:0] addr_of(input logic [14:0] b, input int k, input int odd);
    return 15'(int'(b) + 2 * k + odd);
  endfunction

  function automatic logic any_viol(input logic [14:0] b, input int k);
    logic r;
    r = 1'b0;
    for (int j = 0; j < 4; j++)
      r = r | norm_ref(smem[addr_of(b, k, 0)][j]) | norm_ref(smem[addr_of(b, k, 1)][j]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n0, w;
    n0 = ndone;
    w = 0;
    while (ndone == n0 && w < budget) begin
      tick(1);
      w++;
    end
    chk("done_within_budget", 128'(ndone != n0), 128'(1));
  endtask

  // signature memory: registered read, data one cycle after the request
  always @(posedge clk) begin
    if (rd_a.rd_wr_en == RW_READ) rdd_a <= smem[rd_a.addr];
    if (rd_b.rd_wr_en == RW_READ) rdd_b <= smem[rd_b.addr];
  end

  // run-level model: an accepted enable at cycle e puts pair k's read at
  // e+2+k, its write at e+4+k and done at e+4+P
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0;
`ifdef SIGDECODE_Z_NORM_CHK_EN
      m_flag <= 1'b0;
`endif
    end else begin
      cyc <= cyc + 1;
      if (zeroize) begin
        m_act <= 1'b0;
`ifdef SIGDECODE_Z_NORM_CHK_EN
        m_flag <= 1'b0;
`endif
      end else if (en && !(m_act && (cyc - m_e) < P + 4)) begin
        m_act <= 1'b1;
        m_e   <= cyc;
        m_src <= src;
        m_dst <= dst;
`ifdef SIGDECODE_Z_NORM_CHK_EN
        m_flag <= 1'b0;
      end else if (m_act && (cyc - m_e) >= 4 && (cyc - m_e) <= P + 3) begin
        if (any_viol(m_src, cyc - m_e - 4)) m_flag <= 1'b1;
`endif
      end
    end
  end

  // compare every cycle against the model, away from the active edge
  always @(negedge clk) begin
    sig_mem_if_t er_a, er_b;
    mem_if_t ew_a, ew_b;
    logic [3:0][23:0] ed_a, ed_b;
    int d, k;
    logic wv;
    d = cyc - m_e;
    er_a = '0; er_b = '0; ew_a = '0; ew_b = '0;
    ed_a = '0; ed_b = '0;
    if (m_act && d >= 2 && d <= P + 1) begin
      k = d - 2;
      er_a.rd_wr_en = RW_READ; er_a.addr = addr_of(m_src, k, 0);
      er_b.rd_wr_en = RW_READ; er_b.addr = addr_of(m_src, k, 1);
    end
    wv = m_act && d >= 4 && d <= P + 3;
    if (wv) begin
      k = d - 4;
      ew_a.rd_wr_en = RW_WRITE; ew_a.addr = addr_of(m_dst, k, 0);
      ew_b.rd_wr_en = RW_WRITE; ew_b.addr = addr_of(m_dst, k, 1);
      for (int j = 0; j < 4; j++) begin
        ed_a[j] = dec_ref(smem[addr_of(m_src, k, 0)][j]);
        ed_b[j] = dec_ref(smem[addr_of(m_src, k, 1)][j]);
      end
    end
    chk("rd_req", 128'({rd_a, rd_b}), 128'({er_a, er_b}));
    chk("wr_req", 128'({wr_a, wr_b}), 128'({ew_a, ew_b}));
    if (wv) chk("wr_data", 128'({wd_b, wd_a}), 128'({ed_b, ed_a}));
    chk("done", 128'(done), 128'(m_act && d == P + 4));
`ifdef SIGDECODE_Z_NORM_CHK_EN
    chk("z_norm_fail", 128'(nfail), 128'(m_flag));
`endif
    if (rd_a.rd_wr_en == RW_READ) nreads++;
    if (rd_b.rd_wr_en == RW_READ) last_rd_b = rd_b.addr;
    if (wr_b.rd_wr_en == RW_WRITE) last_wr_b = wr_b.addr;
    if (done) ndone++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0;
    // safe fill: all values strictly inside the norm bound
    for (int a = 0; a < 32768; a++)
      for (int j = 0; j < 4; j++)
        smem[a][j] = 20'(200 + ((a * 4 + j) * 7919) % 1048000);
    smem[15'h100] = {20'd1048575, 20'd524289, 20'd524288, 20'd0};
    smem[15'h101] = {20'd0, 20'd524288, 20'd524289, 20'd1048575};
    smem[15'h1000] = {20'd1048455, 20'd121, 20'd1048455, 20'd121};
    smem[15'h1001] = {20'd121, 20'd1048455, 20'd121, 20'd1048455};
    smem[15'h2000] = {20'd300, 20'd300, 20'd300, 20'd120};
    smem[15'h3001] = {20'd1048456, 20'd300, 20'd300, 20'd300};

    // pin the reference decode to hand values
    chk("ref_dec_0",       128'(dec_ref(20'd0)),       128'(24'd524288));
    chk("ref_dec_G",       128'(dec_ref(20'd524288)),  128'(24'd0));
    chk("ref_dec_G+1",     128'(dec_ref(20'd524289)),  128'(24'd8380416));
    chk("ref_dec_max",     128'(dec_ref(20'd1048575)), 128'(24'd7856130));

    // reset state
    @(negedge clk);
    chk("reset_reqs", 128'({rd_a, rd_b, wr_a, wr_b}), 128'(0));
    chk("reset_data", 128'({wd_a, wd_b}), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // full run with decode boundaries in pair 0
    src = 15'h100; dst = 15'h400; n0 = nreads; d0 = ndone;
    en = 1'b1; tick(1); en = 1'b0;
    tick(1); @(negedge clk);
    chk("run1_first_rd_a", 128'(rd_a.addr), 128'(15'h100));
    chk("run1_first_rd_b", 128'(rd_b.addr), 128'(15'h101));
    tick(2); @(negedge clk);
    chk("run1_wr0_addr", 128'({wr_a.addr, wr_b.addr}), 128'({15'h400, 15'h401}));
    chk("run1_lanes_a", 128'(wd_a), 128'({24'd7856130, 24'd8380416, 24'd0, 24'd524288}));
    chk("run1_lanes_b", 128'(wd_b), 128'({24'd524288, 24'd0, 24'd8380416, 24'd7856130}));
    wait_done(300);
    chk("run1_pairs", 128'(nreads - n0), 128'(224));
    chk("run1_last_rd", 128'(last_rd_b), 128'(15'h2BF));
    chk("run1_last_wr", 128'(last_wr_b), 128'(15'h5BF));
    tick(5);
    chk("run1_one_done", 128'(ndone - d0), 128'(1));
`ifdef SIGDECODE_Z_NORM_CHK_EN
    chk("run1_flag", 128'(nfail), 128'(1));
`endif

    // enable held high, bases changed mid-run, addresses wrap
    src = 15'h7F80; dst = 15'h7FC0; d0 = ndone;
    en = 1'b1; tick(10);
    src = 15'h0050; dst = 15'h0060;
    wait_done(300);
    en = 1'b0;
    chk("hold_one_done", 128'(ndone - d0), 128'(1));
    tick(1); @(negedge clk);
    chk("hold_second_src", 128'({rd_a.addr, rd_b.addr}), 128'({15'h0050, 15'h0051}));
    wait_done(300);
    tick(3);

    // zeroize at read pair 50
    src = 15'h200; dst = 15'h600;
    en = 1'b1; tick(1); en = 1'b0;
    tick(51);
    zeroize = 1'b1;
    @(negedge clk);
    chk("zero_pair50", 128'({rd_a.addr, rd_b.addr}), 128'({15'h264, 15'h265}));
    tick(1);
    zeroize = 1'b0;
    @(negedge clk);
    chk("zero_reqs", 128'({rd_a, rd_b, wr_a, wr_b}), 128'(0));
    chk("zero_data", 128'({wd_a, wd_b}), 128'(0));
    d0 = ndone;
    tick(300);
    chk("zero_no_done", 128'(ndone - d0), 128'(0));
    en = 1'b1; tick(1); en = 1'b0;
    tick(1); @(negedge clk);
    chk("zero_restart", 128'(rd_a.addr), 128'(15'h200));
    wait_done(300);
    tick(2);

    // asynchronous reset mid-run
    src = 15'h300; dst = 15'h700;
    en = 1'b1; tick(1); en = 1'b0;
    tick(51);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_reqs", 128'({rd_a, rd_b, wr_a, wr_b}), 128'(0));
    chk("rst_data", 128'({wd_a, wd_b, done}), 128'(0));
    d0 = ndone;
    tick(2);
    reset_n = 1'b1;
    tick(250);
    chk("rst_no_done", 128'(ndone - d0), 128'(0));
    en = 1'b1; tick(1); en = 1'b0;
    tick(1); @(negedge clk);
    chk("rst_restart", 128'(rd_a.addr), 128'(15'h300));
    wait_done(300);
    tick(2);

`ifdef SIGDECODE_Z_NORM_CHK_EN
    // v = 121 / 1048455 sit just inside the bound
    src = 15'h1000; dst = 15'h4000;
    en = 1'b1; tick(1); en = 1'b0;
    @(negedge clk);
    chk("norm_clear_on_en", 128'(nfail), 128'(0));
    wait_done(300);
    chk("norm_safe", 128'(nfail), 128'(0));
    tick(2);
    // v = 120 violates
    src = 15'h2000; dst = 15'h4000;
    en = 1'b1; tick(1); en = 1'b0;
    tick(3); @(negedge clk);
    chk("norm_120_before", 128'(nfail), 128'(0));
    tick(1); @(negedge clk);
    chk("norm_120_set", 128'(nfail), 128'(1));
    wait_done(300);
    tick(2);
    // v = 1048456 violates; flag cleared by the new enable first
    src = 15'h3000; dst = 15'h4000;
    en = 1'b1; tick(1); en = 1'b0;
    @(negedge clk);
    chk("norm_cleared", 128'(nfail), 128'(0));
    tick(4); @(negedge clk);
    chk("norm_hi_set", 128'(nfail), 128'(1));
    wait_done(300);
    zeroize = 1'b1; tick(1); zeroize = 1'b0;
    @(negedge clk);
    chk("norm_zeroize", 128'(nfail), 128'(0));
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sigdecode_z_seq.md
Name: sigdecode_z_seq

Overview:
- Verifier-side counterpart of the z signature encoder.
- Streams packed (GAMMA1+1)-bit z words out of signature memory through two read ports, four coefficients per port per cycle.
- Maps each word back to a coefficient mod q and writes 4xREG_SIZE-bit words into main coefficient memory through two write ports.
- Handles NUM_POLY contiguous polynomials per enable, feeding the NTT/verify pipeline.

Parameters:
- MEM_ADDR_WIDTH, ABR_MEM_ADDR_WIDTH: width of all address fields.
- REG_SIZE, 24: output coefficient width.
- GAMMA1, 19: log2(gamma1); input field width is GAMMA1+1.
- NUM_POLY, 7: polynomials per run (l); must be at least 1.
- BETA, 120: norm bound offset, used only with the optional feature.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state
- sigdecode_z_enable  in  1  start pulse; sampled in IDLE only
- src_base_addr  in  MEM_ADDR_WIDTH  signature-memory base, locked at start
- dest_base_addr  in  MEM_ADDR_WIDTH  coefficient-memory base, locked at start
- sigmem_a_rd_req  out  sig_mem_if_t  read request, even addresses
- sigmem_b_rd_req  out  sig_mem_if_t  read request, odd addresses
- sigmem_a_rd_data  in  [3:0][GAMMA1:0]  packed words, port a
- sigmem_b_rd_data  in  [3:0][GAMMA1:0]  packed words, port b
- mem_a_wr_req  out  mem_if_t  write request, even addresses
- mem_b_wr_req  out  mem_if_t  write request, odd addresses
- mem_a_wr_data  out  [3:0][REG_SIZE-1:0]  decoded coefficients, port a
- mem_b_wr_data  out  [3:0][REG_SIZE-1:0]  decoded coefficients, port b
- sigdecode_z_done  out  1  one-cycle completion pulse
- z_norm_fail  out  1  sticky norm violation; present only with the optional feature

Behaviour:
- Reset and zeroize:
  - All requests are rd_wr_en=RW_IDLE, addr=0.
  - Data outputs, done, counters and locked addresses are 0; state is IDLE.
  - Zeroize mid-run aborts immediately; no further requests are issued and no done pulse is produced.
- Run length: W = NUM_POLY*MLDSA_N/4 words (448 at default); P = W/2 read pairs (224).
- States: IDLE -> RD -> RD_WR -> DRAIN1 -> DRAIN2 -> DONE -> IDLE.
  - IDLE: on enable, lock both base addresses, clear rd_cnt, go to RD.
  - RD: one cycle; issues read pair 0.
  - RD_WR: issues read pairs until rd_cnt == P-1; then DRAIN1.
  - DRAIN1, DRAIN2: no reads; flush the write pipeline.
  - DONE: registered done goes high the following cycle for exactly one cycle.
- Enable is ignored outside IDLE.
- Read requests (registered):
  - Pair k drives sigmem_a_rd_req = RW_READ at src+2k and sigmem_b_rd_req = RW_READ at src+2k+1.
  - Otherwise both are RW_IDLE with addr 0.
  - Addresses are computed modulo 2^MEM_ADDR_WIDTH (wrap allowed).
- Latency:
  - Read data is valid one cycle after its request is visible.
  - Decode is registered: data valid two cycles after the read request.
  - Write request for pair k is RW_WRITE at dest+2k and dest+2k+1, visible in the same cycle as its decoded data; otherwise RW_IDLE with addr 0.
  - The write stream is the read stream delayed by exactly 2 cycles, gap-free.
  - Done is visible 1 cycle after the last write request is visible.
- Decode per coefficient, v unsigned GAMMA1+1 bits, G = 2^GAMMA1:
  - If v <= G: out = G - v.
  - Else: out = MLDSA_Q + G - v.
  - Zero-extend to REG_SIZE. The result is always in [0, MLDSA_Q-1].

Optional Feature:
- Macro: SIGDECODE_Z_NORM_CHK_EN.
- Defined:
  - Each decoded coefficient's signed z = G - v is checked against |z| >= G - BETA.
  - A violation on any lane of a valid write cycle sets z_norm_fail in the cycle after that write is visible.
  - z_norm_fail stays set until the next accepted enable, zeroize or reset.
  - It does not stall or abort the run.
- Undefined: the z_norm_fail port and all checking logic are absent; all other behaviour is identical.

Test Plan:
- Decode boundaries, default params:
  - v=0 -> 524288.
  - v=524288 -> 0.
  - v=524289 -> 8380416.
  - v=1048575 -> 7856130.
  - All 8 lanes checked.
- Full run, src=0x100, dest=0x400:
  - Exactly 224 read pairs at 0x100..0x2BF.
  - Writes at 0x400..0x5BF, each exactly 2 cycles after the matching read.
  - Done pulses once, 1 cycle after the last write.
- Enable held high for the whole run, with bases changed mid-run:
  - Addresses stay on the locked values.
  - A second run starts only from IDLE, after done.
- Zeroize asserted at read pair 50:
  - Next cycle all requests are RW_IDLE addr 0 and data is 0.
  - No done pulse; a fresh enable restarts from pair 0.
- Reset mid-run: same response as the zeroize case, applied asynchronously.
- With SIGDECODE_Z_NORM_CHK_EN:
  - v=121 or v=1048455 -> no flag.
  - v=120 -> flag set.
  - v=1048456 -> flag set.
  - Flag clears on the next enable.
